// File: rtl/move_scheduler_pkg.sv
// rtl/move_scheduler_pkg.sv - move codes, issue FSM states and legality check for move_scheduler
package move_scheduler_pkg;

  localparam int MOVE_W = 4;

  typedef enum logic [MOVE_W-1:0] {
    MV_NOP = 4'd0,
    MV_R   = 4'd2,
    MV_RI  = 4'd3,
    MV_U   = 4'd4,
    MV_UI  = 4'd5,
    MV_F   = 4'd6,
    MV_FI  = 4'd7,
    MV_L   = 4'd8,
    MV_LI  = 4'd9,
    MV_B   = 4'd10,
    MV_BI  = 4'd11,
    MV_D   = 4'd12,
    MV_DI  = 4'd13
  } move_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_SETTLE,
    ST_FAULT
  } sched_state_e;

  function automatic logic is_legal_move(input logic [MOVE_W-1:0] code);
    return (code >= MV_R) && (code <= MV_DI);
  endfunction

endpackage

// File: rtl/move_fifo.sv
// rtl/move_fifo.sv - synchronous first-word-fall-through FIFO holding queued move codes
module move_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 128
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   free_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign free_o  = (AW+1)'(DEPTH) - cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - unpacks move bursts into a queue and issues one face turn at a time
module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter int SEQ_MOVES      = 50,
  parameter int FIFO_DEPTH     = 128,
  parameter int SETTLE_CYCLES  = 250000,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic [4*SEQ_MOVES-1:0]   seq,
  input  logic                     seq_last,
  input  logic                     pause,
  output logic                     load_ready,
  output logic [MOVE_W-1:0]        next_move,
  output logic                     move_start,
  input  logic                     move_done,
  output logic                     busy,
  output logic                     seq_done,
  output logic                     fault,
  output logic [7:0]               bad_codes,
  output logic [7:0]               moves_issued
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int UW      = $clog2(SEQ_MOVES + 1);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [4*SEQ_MOVES-1:0] shift_q;
  logic                   last_q;
  logic [UW-1:0]          ucnt_q;
  logic [7:0]             bad_q;
  logic [7:0]             issued_q;
  logic                   seq_done_q;
  logic                   unpack_active;
  logic                   load_acc;
  logic [MOVE_W-1:0]      nib;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [MOVE_W-1:0]      fifo_rdata;
  logic [AW:0]            fifo_free;

  sched_state_e           state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MOVE_W-1:0]      next_move_q, next_move_d;

  assign unpack_active = (ucnt_q != '0);
  assign load_ready    = !unpack_active && (fifo_free >= (AW+1)'(SEQ_MOVES));
  assign load_acc      = load && load_ready;
  assign nib           = shift_q[MOVE_W-1:0];
  assign fifo_push     = unpack_active && is_legal_move(nib);

  move_fifo #(.WIDTH(MOVE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i    (clock),
    .resetn_i (reset_n),
    .push_i   (fifo_push),
    .wdata_i  (nib),
    .pop_i    (fifo_pop),
    .rdata_o  (fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .free_o   (fifo_free)
  );

  // Load gating guarantees room for a whole burst, so this should never fire.
  always_ff @(posedge clock) begin
    if (reset_n) assert (!(fifo_push && fifo_full));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shift_q <= '0;
      last_q  <= 1'b0;
      ucnt_q  <= '0;
      bad_q   <= '0;
    end else if (load_acc) begin
      shift_q <= seq;
      last_q  <= seq_last;
      ucnt_q  <= UW'(SEQ_MOVES);
    end else if (unpack_active) begin
      shift_q <= shift_q >> MOVE_W;
      ucnt_q  <= ucnt_q - 1'b1;
      if (!is_legal_move(nib) && (nib != MV_NOP) && (bad_q != 8'hFF)) bad_q <= bad_q + 8'd1;
    end
  end

  // One counter serves both the WAIT watchdog and the SETTLE gap; it is
  // seeded with 1 so the IDLE cycle after SETTLE completes the settle budget.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    next_move_d = next_move_q;
    fifo_pop    = 1'b0;
    move_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !pause) begin
          fifo_pop    = 1'b1;
          next_move_d = fifo_rdata;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        move_start = 1'b1;
        cnt_d      = CNT_W'(1);
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (move_done) begin
          cnt_d   = CNT_W'(1);
          state_d = ST_SETTLE;
        end else if (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q >= CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      next_move_q <= '0;
      issued_q    <= '0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      next_move_q <= next_move_d;
      if (move_start) issued_q <= issued_q + 8'd1;
      if (load_acc) seq_done_q <= 1'b0;
      else if (last_q && !unpack_active && fifo_empty && (state_q == ST_IDLE)) seq_done_q <= 1'b1;
    end
  end

  assign next_move    = next_move_q;
  assign fault        = (state_q == ST_FAULT);
  assign busy         = unpack_active || !fifo_empty || ((state_q != ST_IDLE) && (state_q != ST_FAULT));
  assign seq_done     = seq_done_q;
  assign bad_codes    = bad_q;
  assign moves_issued = issued_q;

endmodule

// File: tb/tb_move_scheduler.sv
// tb/tb_move_scheduler.sv - directed table-driven bench for move_scheduler with a move_to_step stub
module tb_move_scheduler;
  localparam int SEQ_MOVES = 50;
  localparam int FD        = 64;
  localparam int SC        = 20;
  localparam int TC        = 100;

  logic         clock;
  logic         reset_n;
  logic         load;
  logic [199:0] seq;
  logic         seq_last;
  logic         pause;
  logic         load_ready;
  logic [3:0]   next_move;
  logic         move_start;
  logic         move_done;
  logic         busy;
  logic         seq_done;
  logic         fault;
  logic [7:0]   bad_codes;
  logic [7:0]   moves_issued;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         start_cyc[$];
  logic [3:0] start_mv[$];
  bit         stub_answer = 1;
  int         stub_delay = 5;
  int         pending = 0;

  typedef struct {
    logic [199:0] seq;
    int           n;
    logic [15:0]  mv;
    int           first_idx;
    int           bad_inc;
  } vec_t;
  vec_t vecs[5];

  move_scheduler #(
    .SEQ_MOVES(SEQ_MOVES), .FIFO_DEPTH(FD), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clock(clock), .reset_n(reset_n), .load(load), .seq(seq), .seq_last(seq_last),
    .pause(pause), .load_ready(load_ready), .next_move(next_move), .move_start(move_start),
    .move_done(move_done), .busy(busy), .seq_done(seq_done), .fault(fault),
    .bad_codes(bad_codes), .moves_issued(moves_issued)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(negedge clock);
    if (move_start === 1'b1) begin
      start_cyc.push_back(cyc);
      start_mv.push_back(next_move);
    end
  end

  // move_to_step stub: answers stub_delay cycles after each start pulse.
  initial begin
    move_done = 1'b0;
    forever begin
      @(negedge clock);
      move_done = 1'b0;
      if (!reset_n) pending = 0;
      else if (move_start === 1'b1 && stub_answer) pending = stub_delay;
      else if (pending > 0) begin
        pending--;
        if (pending == 0) move_done = 1'b1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_start(input int bound, output int at, output bit ok);
    ok = 0;
    at = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clock);
      if (move_start === 1'b1) begin
        ok = 1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_seq_done(input int bound, output bit ok);
    ok = 0;
    for (int k = 0; k < bound; k++) begin
      if (seq_done === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clock);
    end
  endtask

  logic [199:0] seq_a, seq_b;
  logic [3:0]   exp_all[$];
  logic [3:0]   exp_nib;
  int           l_cyc, s_cyc, p_cyc, acc_cyc, bad0, n0, errs, gaps;
  bit           ok;

  initial begin
    reset_n = 1'b0; load = 1'b0; seq = '0; seq_last = 1'b0; pause = 1'b0;
    vecs[0] = '{200'hA2,    2, 16'h00A2, 0, 0};
    vecs[1] = '{200'h4FE1,  1, 16'h0004, 3, 3};
    vecs[2] = '{200'h0,     0, 16'h0000, 0, 0};
    vecs[3] = '{200'h3D0,   2, 16'h003D, 1, 0};
    vecs[4] = '{200'h7CF05, 3, 16'h07C5, 0, 1};

    repeat (3) @(negedge clock);
    check("rst_load_ready", load_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_seq_done", seq_done, 0);
    check("rst_fault", fault, 0);
    check("rst_next_move", next_move, 0);
    check("rst_move_start", move_start, 0);
    check("rst_counters", {bad_codes, moves_issued}, 0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 5; v++) begin
      start_cyc.delete(); start_mv.delete();
      bad0 = bad_codes;
      load = 1'b1; seq = vecs[v].seq; seq_last = 1'b1; l_cyc = cyc;
      @(negedge clock);
      load = 1'b0;
      check("seq_done_clear", seq_done, 0);
      check("load_ready_drop", load_ready, 0);
      @(negedge clock);
      load = 1'b1; seq = 200'h2222; seq_last = 1'b0;
      @(negedge clock);
      load = 1'b0;
      wait_seq_done(1000, ok);
      check("seq_done_set", ok, 1);
      check("idle_busy", busy, 0);
      check("bad_codes", bad_codes, bad0 + vecs[v].bad_inc);
      check("start_count", start_mv.size(), vecs[v].n);
      for (int j = 0; j < vecs[v].n && j < start_mv.size(); j++) begin
        exp_nib = vecs[v].mv[4*j +: 4];
        check("move_code", start_mv[j], exp_nib);
        if (j == 0) check("first_latency", start_cyc[0] - l_cyc, 3 + vecs[v].first_idx);
        else check("start_spacing", start_cyc[j] - start_cyc[j-1], 26);
      end
    end
    check("issued_after_table", moves_issued, 8);
    check("bad_after_table", bad_codes, 4);

    // Two full bursts into a 64-deep queue: second waits for 50 free entries.
    exp_all.delete();
    for (int i = 0; i < 50; i++) begin
      seq_a[4*i +: 4] = 4'(2 + (i % 12));
      exp_all.push_back(4'(2 + (i % 12)));
    end
    for (int i = 0; i < 50; i++) begin
      seq_b[4*i +: 4] = 4'(2 + ((i + 5) % 12));
      exp_all.push_back(4'(2 + ((i + 5) % 12)));
    end
    start_cyc.delete(); start_mv.delete();
    load = 1'b1; seq = seq_a; seq_last = 1'b0; l_cyc = cyc;
    @(negedge clock);
    seq = seq_b; seq_last = 1'b1;
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      if (load_ready) begin
        ok = 1;
        break;
      end
      @(negedge clock);
    end
    acc_cyc = cyc;
    check("second_load_ready", ok, 1);
    @(negedge clock);
    load = 1'b0;
    check("second_held", (acc_cyc - l_cyc) > 60, 1);
    check("starts_at_second_load", start_mv.size(), 36);
    wait_seq_done(4000, ok);
    check("two_burst_done", ok, 1);
    check("two_burst_count", start_mv.size(), 100);
    errs = 0; gaps = 0;
    for (int j = 0; j < start_mv.size() && j < 100; j++) begin
      if (start_mv[j] !== exp_all[j]) errs++;
      if (j > 0 && (start_cyc[j] - start_cyc[j-1]) != 26) gaps++;
    end
    check("two_burst_order_errs", errs, 0);
    check("two_burst_gap_errs", gaps, 0);
    check("issued_wrap_count", moves_issued, 108);

    // Watchdog: stub never answers.
    stub_answer = 0;
    start_cyc.delete(); start_mv.delete();
    load = 1'b1; seq = 200'h2; seq_last = 1'b1;
    @(negedge clock);
    load = 1'b0;
    wait_start(20, s_cyc, ok);
    check("timeout_start_seen", ok, 1);
    repeat (99) @(negedge clock);
    check("fault_before_limit", fault, 0);
    check("busy_while_wait", busy, 1);
    @(negedge clock);
    check("fault_at_limit", fault, 1);
    check("fault_not_busy", busy, 0);
    load = 1'b1; seq = 200'h3; seq_last = 1'b1;
    @(negedge clock);
    load = 1'b0;
    repeat (200) @(negedge clock);
    check("no_start_after_fault", start_mv.size(), 1);
    check("fault_sticky", fault, 1);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    check("fault_cleared", fault, 0);
    check("issued_cleared", moves_issued, 0);
    stub_answer = 1;
    @(negedge clock);

    // Pause during WAIT parks after the move; reset mid-SETTLE abandons the rest.
    start_cyc.delete(); start_mv.delete();
    load = 1'b1; seq = 200'h543; seq_last = 1'b1;
    @(negedge clock);
    load = 1'b0;
    wait_start(20, s_cyc, ok);
    check("pause_first_start", ok, 1);
    repeat (2) @(negedge clock);
    pause = 1'b1;
    repeat (98) @(negedge clock);
    check("pause_parked_starts", start_mv.size(), 1);
    check("pause_busy", busy, 1);
    check("pause_next_move", next_move, 3);
    pause = 1'b0; p_cyc = cyc;
    wait_start(10, s_cyc, ok);
    check("resume_latency", s_cyc - p_cyc, 1);
    check("resume_move", next_move, 4);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_next_move", next_move, 0);
    check("mid_rst_issued", moves_issued, 0);
    check("mid_rst_load_ready", load_ready, 1);
    reset_n = 1'b1;
    n0 = start_mv.size();
    repeat (60) @(negedge clock);
    check("no_start_after_reset", start_mv.size(), n0);
    check("idle_after_reset", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
